// File: rtl/path_delay_probe_pkg.sv
// Shared types and constants for the ring-oscillator path delay probe.
package path_delay_probe_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } probe_state_e;

    localparam int unsigned DRAIN_CYCLES = 2;

    // One bit of headroom above the largest phase length.
    function automatic int unsigned timer_width(input int unsigned settle,
                                                input int unsigned window);
        int unsigned m;
        m = (settle > window) ? settle : window;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/path_delay_probe_if.sv
// Host-side handshake bundle: start request, busy flag and the valid/ready result.
interface path_delay_probe_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             sat;
    logic             valid;
    logic             ready;

    modport master (output start, ready, input busy, count, sat, valid);
    modport slave  (input start, ready, output busy, count, sat, valid);
endinterface

// File: rtl/path_delay_probe_sync_edge_det.sv
// Two-flop synchronizer plus an edge flop; flags a rising edge of the synchronized input.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/path_delay_probe.sv
// Closes the delay path into a ring, lets it settle, then counts its edges over a fixed window.
module path_delay_probe
    import path_delay_probe_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    path_delay_probe_if.slave host,
    output logic              ro_en,
    input  logic              ro_in
);
    localparam int unsigned TMR_W = timer_width(SETTLE_CYCLES, WINDOW_CYCLES);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRAIN_LOAD  = TMR_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    probe_state_e     state_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] count_q;
    logic             sat_q;
    logic             valid_q;
    logic             busy_q;
    logic             ro_en_q;
    logic             rise;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ro_in),
        .rise     (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ro_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (host.start) begin
                        ro_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        timer_q <= SETTLE_LOAD;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer_q == '0) begin
                        count_q <= '0;
                        sat_q   <= 1'b0;
                        timer_q <= WINDOW_LOAD;
                        state_q <= MEASURE;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                MEASURE: begin
                    // A rise arriving with the count already full is dropped and flagged.
                    if (rise) begin
                        if (count_q == CNT_MAX) begin
                            sat_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    if (timer_q == '0) begin
                        ro_en_q <= 1'b0;
                        timer_q <= DRAIN_LOAD;
                        state_q <= DRAIN;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                DRAIN: begin
                    // The phase timer is reused to space out the drain cycles.
                    if (timer_q == '0) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                DONE: begin
                    if (host.ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign host.count = count_q;
    assign host.sat   = sat_q;
    assign host.valid = valid_q;
    assign host.busy  = busy_q;
    assign ro_en      = ro_en_q;
endmodule

// File: tb/tb_path_delay_probe.sv
// Scoreboarded random test of path_delay_probe at two counter widths sharing one ring input.
module tb_path_delay_probe;
    localparam int unsigned S     = 4;
    localparam int unsigned W     = 16;
    localparam int unsigned CW_A  = 4;
    localparam int unsigned CW_B  = 2;
    localparam int unsigned NSAMP = 8192;
    localparam int unsigned LAT   = S + W + 2;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic ro_in = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic ro_en_a, ro_en_b;

    path_delay_probe_if #(.CNT_W(CW_A)) if_a ();
    path_delay_probe_if #(.CNT_W(CW_B)) if_b ();

    assign if_a.start = start;
    assign if_a.ready = ready;
    assign if_b.start = start;
    assign if_b.ready = ready;

    path_delay_probe #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .host(if_a), .ro_en(ro_en_a), .ro_in(ro_in)
    );
    path_delay_probe #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .host(if_b), .ro_en(ro_en_b), .ro_in(ro_in)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ro_in as seen at each rising clk edge; edge index j is stored in samp[j].
    int unsigned cyc = 0;
    bit          samp [NSAMP];
    always @(posedge clk) begin
        if (cyc < NSAMP) samp[cyc] = ro_in;
        cyc = cyc + 1;
    end

    // Ring model: 0 = stuck low, 1 = square wave with half-period ro_half, 2 = random level.
    int unsigned ro_mode = 1;
    int unsigned ro_half = 1;
    int unsigned ro_ph   = 0;
    always @(negedge clk) begin
        case (ro_mode)
            0: ro_in = 1'b0;
            1: begin
                ro_ph++;
                if (ro_ph >= ro_half) begin
                    ro_ph = 0;
                    ro_in = ~ro_in;
                end
            end
            default: ro_in = 1'($urandom_range(0, 1));
        endcase
    end

    // Rising edges of ro_in that land inside the counting window of a start taken at edge t,
    // after the two-cycle synchronizer delay.
    function automatic int unsigned model_edges(input int unsigned t);
        int unsigned n = 0;
        for (int unsigned e = t + S + 1; e <= t + S + W; e++) begin
            if (samp[e-2] && !samp[e-3]) n++;
        end
        return n;
    endfunction

    int unsigned sb_q [$];

    // Monitor: samples 1 time unit after each rising edge.
    logic        prev_valid = 1'b0;
    int unsigned en_cnt = 0;
    int unsigned exp_ca, exp_cb;
    bit          exp_sa, exp_sb;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_valid = 1'b0;
            en_cnt     = 0;
        end else begin
            int unsigned t, n;
            if (ro_en_a) en_cnt++;
            if (if_a.valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    t      = sb_q.pop_front();
                    n      = model_edges(t);
                    exp_ca = (n > 15) ? 15 : n;
                    exp_sa = (n > 15);
                    exp_cb = (n > 3) ? 3 : n;
                    exp_sb = (n > 3);
                    check("latency",   longint'(cyc - 1 - t), LAT);
                    check("ro_en_len", en_cnt, S + W);
                    check("count_a",   if_a.count, exp_ca);
                    check("sat_a",     if_a.sat, exp_sa);
                    check("valid_b",   if_b.valid, 1);
                    check("count_b",   if_b.count, exp_cb);
                    check("sat_b",     if_b.sat, exp_sb);
                end
                en_cnt = 0;
            end else if (if_a.valid) begin
                check("hold_count_a", if_a.count, exp_ca);
                check("hold_sat_a",   if_a.sat, exp_sa);
                check("hold_count_b", if_b.count, exp_cb);
                check("hold_sat_b",   if_b.sat, exp_sb);
                check("hold_ro_en",   ro_en_a, 0);
            end
            prev_valid = if_a.valid;
        end
    end

    task automatic do_start();
        start = 1'b1;
        sb_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if_a.valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_valid: got no valid, expected valid within 40 cycles");
            rst = 1'b1;
            sb_q.delete();
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    // Hold ready low for 'delay' cycles (optionally pulsing start), then accept with start raised.
    task automatic accept(input int unsigned delay, input bit pulse);
        for (int unsigned i = 0; i < delay; i++) begin
            start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("done_busy", if_a.busy, 1);
        end
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        start = 1'b0;
        check("acc_valid", if_a.valid, 0);
        check("acc_busy",  if_a.busy, 0);
        check("acc_ro_en", ro_en_a, 0);
        @(negedge clk);
        check("idle_busy", if_a.busy, 0);
    endtask

    task automatic measure(input int unsigned delay, input bit pulse);
        bit ok;
        do_start();
        wait_valid(ok);
        if (ok) accept(delay, pulse);
    endtask

    initial begin
        bit ok;
        int unsigned seen;

        // Reset with the ring input toggling.
        ro_mode = 1;
        ro_half = 1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ro_en", ro_en_a, 0);
        check("rst_busy",  if_a.busy, 0);
        check("rst_valid", if_a.valid, 0);
        check("rst_count", if_a.count, 0);
        check("rst_sat",   if_a.sat, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_ro_en", ro_en_a, 0);
        check("idle_valid", if_a.valid, 0);
        check("idle_count", if_a.count, 0);
        check("idle_busy0", if_a.busy, 0);

        // Basic: period 4 gives exactly 4 edges in a 16-cycle window.
        ro_half = 2;
        do_start();
        check("busy_after_start", if_a.busy, 1);
        check("ro_en_after_start", ro_en_a, 1);
        wait_valid(ok);
        if (ok) begin
            check("basic_count", if_a.count, 4);
            check("basic_sat",   if_a.sat, 0);
            accept(0, 1'b0);
        end

        // Saturation on the 2-bit instance: period 2 gives 8 edges.
        ro_half = 1;
        do_start();
        wait_valid(ok);
        if (ok) begin
            check("satur_count_b", if_b.count, 3);
            check("satur_sat_b",   if_b.sat, 1);
            accept(0, 1'b0);
        end

        // Back-pressure with start pulses while the result is held.
        ro_mode = 2;
        measure(10, 1'b1);

        // A start pulse mid-measurement must not restart the window.
        do_start();
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(ok);
        if (ok) accept(2, 1'b0);

        // Abort during MEASURE.
        ro_mode = 1;
        ro_half = 2;
        do_start();
        repeat (S + 6) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_ro_en", ro_en_a, 0);
        check("abort_busy",  if_a.busy, 0);
        check("abort_valid", if_a.valid, 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (if_a.valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        do_start();
        wait_valid(ok);
        if (ok) begin
            check("post_abort_count", if_a.count, 4);
            accept(0, 1'b0);
        end

        // Static path.
        ro_mode = 0;
        repeat (4) @(negedge clk);
        do_start();
        wait_valid(ok);
        if (ok) begin
            check("static_count", if_a.count, 0);
            check("static_sat",   if_a.sat, 0);
            accept(1, 1'b0);
        end

        // Random ring behaviour and host back-pressure.
        for (int i = 0; i < 20; i++) begin
            ro_mode = $urandom_range(1, 2);
            ro_half = $urandom_range(1, 5);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            measure($urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
